// File: rtl/cex_pkg.sv
//------------------------------------------------------------------------------
// Module      : cex_pkg
// Description : Shared condition-code constants, PSW bit indices and the
//               CEX sequencer state type for the XM-23 condition-code unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cex_pkg;

    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_MI = 4'd4;
    localparam logic [3:0] CC_PL = 4'd5;
    localparam logic [3:0] CC_VS = 4'd6;
    localparam logic [3:0] CC_VC = 4'd7;
    localparam logic [3:0] CC_HI = 4'd8;
    localparam logic [3:0] CC_LS = 4'd9;
    localparam logic [3:0] CC_GE = 4'd10;
    localparam logic [3:0] CC_LT = 4'd11;
    localparam logic [3:0] CC_GT = 4'd12;
    localparam logic [3:0] CC_LE = 4'd13;
    localparam logic [3:0] CC_TR = 4'd14;
    localparam logic [3:0] CC_FL = 4'd15;

    localparam int PSW_C   = 0;
    localparam int PSW_Z   = 1;
    localparam int PSW_N   = 2;
    localparam int PSW_SLP = 3;
    localparam int PSW_V   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRUE_PH  = 2'd1,
        ST_FALSE_PH = 2'd2
    } cex_state_t;

endpackage

`default_nettype wire

// File: rtl/cex_cond_eval.sv
//------------------------------------------------------------------------------
// Module      : cex_cond_eval
// Description : Combinational evaluation of a 4-bit condition code against
//               the C/Z/N/V flags of the PSW.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cex_cond_eval
    import cex_pkg::*;
(
    input  logic [15:0] psw,
    input  logic [3:0]  code,
    output logic        cond
);

    logic w_c, w_z, w_n, w_v;
    logic w_unused_psw;

    assign w_c = psw[PSW_C];
    assign w_z = psw[PSW_Z];
    assign w_n = psw[PSW_N];
    assign w_v = psw[PSW_V];

    // SLP and the upper PSW bits never affect a condition
    assign w_unused_psw = ^{psw[15:5], psw[PSW_SLP]};

    always_comb begin
        cond = 1'b0;
        case (code)
            CC_EQ: cond = w_z;
            CC_NE: cond = !w_z;
            CC_CS: cond = w_c;
            CC_CC: cond = !w_c;
            CC_MI: cond = w_n;
            CC_PL: cond = !w_n;
            CC_VS: cond = w_v;
            CC_VC: cond = !w_v;
            CC_HI: cond = w_c & !w_z;
            CC_LS: cond = !w_c | w_z;
            CC_GE: cond = (w_n == w_v);
            CC_LT: cond = (w_n != w_v);
            CC_GT: cond = !w_z & (w_n == w_v);
            CC_LE: cond = w_z | (w_n != w_v);
            CC_TR: cond = 1'b1;
            CC_FL: cond = 1'b0;
            default: cond = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cex_code_unit.sv
//------------------------------------------------------------------------------
// Module      : cex_code_unit
// Description : Registered condition-code evaluator with an optional CEX
//               true/false window sequencer (enabled by CEX_SEQUENCER_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cex_code_unit
    import cex_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] psw,
    input  logic [3:0]  code,
    output logic        code_result,
    input  logic        cex_start,
    input  logic [2:0]  t_count,
    input  logic [2:0]  f_count,
    input  logic        instr_done,
    output logic        exec_enable,
    output logic        cex_active
);

    logic w_cond;
    logic r_code_result;

    cex_cond_eval u_cond_eval (
        .psw  (psw),
        .code (code),
        .cond (w_cond)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_code_result <= 1'b0;
        end else begin
            r_code_result <= w_cond;
        end
    end

    assign code_result = r_code_result;

`ifdef CEX_SEQUENCER_EN

    cex_state_t r_state, w_state_nxt;
    logic [2:0] r_t_cnt, r_f_cnt, w_t_nxt, w_f_nxt;
    logic       r_cond, w_cond_nxt;

    // cex_start has priority: a simultaneous instr_done is dropped
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t_cnt;
        w_f_nxt     = r_f_cnt;
        w_cond_nxt  = r_cond;
        if (cex_start) begin
            w_cond_nxt = w_cond;
            w_t_nxt    = t_count;
            w_f_nxt    = f_count;
            if (t_count != 3'd0) begin
                w_state_nxt = ST_TRUE_PH;
            end else if (f_count != 3'd0) begin
                w_state_nxt = ST_FALSE_PH;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else if (instr_done) begin
            case (r_state)
                ST_TRUE_PH: begin
                    w_t_nxt = r_t_cnt - 3'd1;
                    if (r_t_cnt == 3'd1) begin
                        w_state_nxt = (r_f_cnt != 3'd0) ? ST_FALSE_PH : ST_IDLE;
                    end
                end
                ST_FALSE_PH: begin
                    w_f_nxt = r_f_cnt - 3'd1;
                    if (r_f_cnt == 3'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_t_cnt <= 3'd0;
            r_f_cnt <= 3'd0;
            r_cond  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t_cnt <= w_t_nxt;
            r_f_cnt <= w_f_nxt;
            r_cond  <= w_cond_nxt;
        end
    end

    always_comb begin
        exec_enable = 1'b1;
        case (r_state)
            ST_TRUE_PH:  exec_enable = r_cond;
            ST_FALSE_PH: exec_enable = !r_cond;
            default:     exec_enable = 1'b1;
        endcase
    end

    assign cex_active = (r_state != ST_IDLE);

`else

    logic w_unused_seq;
    assign w_unused_seq = ^{cex_start, t_count, f_count, instr_done};

    assign exec_enable = 1'b1;
    assign cex_active  = 1'b0;

`endif

endmodule

`default_nettype wire

// File: tb/tb_cex_code_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_cex_code_unit
// Description : Directed self-checking bench for cex_code_unit; sequencer
//               expectations collapse to idle when CEX_SEQUENCER_EN is undefined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cex_code_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] psw;
    logic [3:0]  code;
    logic        code_result;
    logic        cex_start;
    logic [2:0]  t_count;
    logic [2:0]  f_count;
    logic        instr_done;
    logic        exec_enable;
    logic        cex_active;

    int n_checks = 0;
    int n_fails  = 0;

    cex_code_unit dut (
        .clock       (clock),
        .reset       (reset),
        .psw         (psw),
        .code        (code),
        .code_result (code_result),
        .cex_start   (cex_start),
        .t_count     (t_count),
        .f_count     (f_count),
        .instr_done  (instr_done),
        .exec_enable (exec_enable),
        .cex_active  (cex_active)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Without the sequencer every window expectation degenerates to idle
    task automatic check_seq(input string tag, input logic exp_active, input logic exp_enable);
`ifdef CEX_SEQUENCER_EN
        check({tag, "_active"}, cex_active, exp_active);
        check({tag, "_enable"}, exec_enable, exp_enable);
`else
        check({tag, "_active"}, cex_active, exp_active & 1'b0);
        check({tag, "_enable"}, exec_enable, exp_enable | 1'b1);
`endif
    endtask

    function automatic logic ref_cond(input logic [3:0] cc, input logic c, input logic z,
                                      input logic n, input logic v);
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic pulse_start(input logic [3:0] cc, input logic [15:0] p,
                               input logic [2:0] t, input logic [2:0] f, input logic done);
        code = cc; psw = p; t_count = t; f_count = f;
        cex_start = 1'b1; instr_done = done;
        tick();
        cex_start = 1'b0; instr_done = 1'b0;
    endtask

    task automatic pulse_done();
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; psw = 16'h0002; code = 4'd0;
        cex_start = 1'b0; t_count = 3'd0; f_count = 3'd0; instr_done = 1'b0;
        tick();
        tick();
        check("reset_code_result", code_result, 1'b0);
        check_seq("reset", 1'b0, 1'b1);
        reset = 1'b0;

        // Hand-computed directed conditions
        psw = 16'h0002; code = 4'd0;  tick(); check("eq_z1", code_result, 1'b1);
        psw = 16'h0002; code = 4'd1;  tick(); check("ne_z1", code_result, 1'b0);
        psw = 16'h0014; code = 4'd10; tick(); check("ge_n1v1", code_result, 1'b1);
        psw = 16'h0014; code = 4'd12; tick(); check("gt_n1v1", code_result, 1'b1);
        psw = 16'h0016; code = 4'd13; tick(); check("le_z1n1v1", code_result, 1'b1);
        psw = 16'h0010; code = 4'd11; tick(); check("lt_n0v1", code_result, 1'b1);
        psw = 16'hFFE8; code = 4'd15; tick(); check("fl_junk", code_result, 1'b0);

        // Exhaustive: 16 codes x 16 flag patterns; SLP/upper bits toggled as noise
        for (int cc = 0; cc < 16; cc++) begin
            for (int fl = 0; fl < 16; fl++) begin
                logic [3:0] f4;
                f4 = fl[3:0];
                code = cc[3:0];
                psw = {11'h5A5 ^ {11{f4[0]}}, f4[3], cc[0], f4[2], f4[1], f4[0]};
                tick();
                check($sformatf("cc%0d_f%0h", cc, fl), code_result,
                      ref_cond(cc[3:0], f4[0], f4[1], f4[2], f4[3]));
            end
        end

        // True path: EQ with Z=1, T=2, F=1 -> 1,1,0 then idle
        pulse_start(4'd0, 16'h0002, 3'd2, 3'd1, 1'b0);
        psw = 16'h0000;  // condition must stay latched
        check_seq("tp_i0", 1'b1, 1'b1);
        pulse_done(); check_seq("tp_i1", 1'b1, 1'b1);
        pulse_done(); check_seq("tp_i2", 1'b1, 1'b0);
        pulse_done(); check_seq("tp_end", 1'b0, 1'b1);
        pulse_done(); check_seq("tp_idle_done", 1'b0, 1'b1);

        // False path: EQ with Z=0, T=0, F=2
        pulse_start(4'd0, 16'h0000, 3'd0, 3'd2, 1'b0);
        check_seq("fp_i0", 1'b1, 1'b1);
        pulse_done(); check_seq("fp_i1", 1'b1, 1'b1);
        pulse_done(); check_seq("fp_end", 1'b0, 1'b1);

        // T=0, F=0 stays idle
        pulse_start(4'd14, 16'h0000, 3'd0, 3'd0, 1'b0);
        check_seq("zero_win", 1'b0, 1'b1);

        // True path whose condition is false, F=0
        pulse_start(4'd1, 16'h0002, 3'd1, 3'd0, 1'b0);
        check_seq("ne_false", 1'b1, 1'b0);
        pulse_done(); check_seq("ne_false_end", 1'b0, 1'b1);

        // Restart with a simultaneous instr_done: new T=1/F=1 loaded, done dropped
        pulse_start(4'd14, 16'h0000, 3'd3, 3'd0, 1'b0);
        pulse_done(); check_seq("rs_pre", 1'b1, 1'b1);
        pulse_start(4'd15, 16'h0000, 3'd1, 3'd1, 1'b1);
        check_seq("rs_load", 1'b1, 1'b0);
        pulse_done(); check_seq("rs_false", 1'b1, 1'b1);
        pulse_done(); check_seq("rs_end", 1'b0, 1'b1);

        // Reset mid-window abandons it
        pulse_start(4'd15, 16'h0000, 3'd5, 3'd2, 1'b0);
        check_seq("rst_win", 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        check_seq("rst_mid", 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        check_seq("rst_after", 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
